// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the shared ALU for its add steps
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter logic [3:0] ADD_OP = 4'b0010
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             AluReq,
  output logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] ALUOut
);
  typedef enum logic [2:0] {IDLE, TEST, ADD, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] product, mcand, mplier;
  // State register and datapath; Result is loaded on entry to DONE so it is valid while Done is high
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      Result  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && Start) begin
        mcand   <= A;
        mplier  <= B;
        product <= '0;
      end
      if (state == ADD) product <= ALUOut;
      if (state == SHIFT) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (state == TEST && mplier == '0) Result <= product;
    end
  end
  // Next state and Moore outputs; ALU ports are only driven during ADD
  always_comb begin
    state_n = (state == IDLE)  ? (Start ? TEST : IDLE) :
              (state == TEST)  ? ((mplier == '0) ? DONE : (mplier[0] ? ADD : SHIFT)) :
              (state == ADD)   ? SHIFT :
              (state == SHIFT) ? TEST : IDLE;
    Busy       = state != IDLE;
    Done       = state == DONE;
    AluReq     = state == ADD;
    ALUControl = AluReq ? ADD_OP : 4'b0000;
    AluA       = AluReq ? product : '0;
    AluB       = AluReq ? mcand : '0;
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed and random multiplies checked against arithmetic expectations
module tb_alu_mul_sequencer;
  localparam logic [3:0] ADD_OP = 4'b0010;
  logic clk = 0;
  logic rst, start, busy, done, alu_req;
  logic [15:0] a_in, b_in, result, alu_a, alu_b, alu_out;
  logic [3:0] alu_control;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign alu_out = (alu_control == ADD_OP) ? alu_a + alu_b : 16'h0000;
  alu_mul_sequencer dut (
    .Clock(clk), .Reset(rst), .Start(start), .A(a_in), .B(b_in),
    .Busy(busy), .Done(done), .Result(result), .AluReq(alu_req),
    .ALUControl(alu_control), .AluA(alu_a), .AluB(alu_b), .ALUOut(alu_out)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold,
                        output int done_cyc, output logic [63:0] req_mask);
    int n, k, adds, busy_low;
    logic [15:0] exp_p;
    exp_p = a * b;
    done_cyc = -1;
    req_mask = '0;
    adds = 0;
    busy_low = 0;
    start = 1;
    a_in = a;
    b_in = b;
    step();
    if (!hold) start = 0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      if (alu_req) begin
        adds++;
        req_mask[c] = 1'b1;
        chk("alu_ctl_add", {60'd0, alu_control}, {60'd0, ADD_OP});
      end else
        chk("alu_idle", {28'd0, alu_control, alu_a, alu_b}, 64'd0);
      if (!busy) busy_low++;
      if (done) done_cyc = c;
      else step();
    end
    n = 0;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    k = $countones(b);
    chk("done_cycle", done_cyc, 2 * n + k + 2);
    chk("alu_adds", adds, k);
    chk("busy_low", busy_low, 0);
    chk("result", {48'd0, result}, {48'd0, exp_p});
  endtask
  initial begin
    int dc;
    logic [63:0] rm;
    logic [15:0] ra, rb, held;
    rst = 1;
    start = 0;
    a_in = '0;
    b_in = '0;
    step();
    step();
    chk("reset_outs", {busy, done, alu_req, alu_control, alu_a, alu_b, result}, 64'd0);
    rst = 0;
    step();
    run_op(16'd3, 16'd5, 0, dc, rm);
    chk("t2_req_cycles", rm, (64'd1 << 2) | (64'd1 << 7));
    step();
    chk("after_done", {done, busy, result}, {2'b00, 16'd15});
    run_op(16'd7, 16'd0, 0, dc, rm);
    chk("b0_no_req", rm, 64'd0);
    step();
    run_op(16'hFFFD, 16'd4, 0, dc, rm);
    chk("neg_result", result, 16'hFFF4);
    step();
    run_op(16'h0100, 16'h0100, 0, dc, rm);
    step();
    run_op(16'hFFFF, 16'hFFFF, 0, dc, rm);
    chk("max_latency", dc, 50);
    step();
    run_op(16'd3, 16'd5, 1, dc, rm);
    a_in = 16'd2;
    b_in = 16'd2;
    step();
    chk("b2b_idle", {done, busy, result}, {2'b00, 16'd15});
    run_op(16'd2, 16'd2, 0, dc, rm);
    step();
    start = 1;
    a_in = 16'd3;
    b_in = 16'd5;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) step();
    rst = 1;
    step();
    chk("abort_state", {busy, alu_req, result}, 18'd0);
    rst = 0;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) held = held + 1;
      step();
    end
    chk("abort_no_done", held, 0);
    run_op(16'd6, 16'd7, 0, dc, rm);
    step();
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      run_op(ra, rb, 0, dc, rm);
      step();
      chk("rand_hold", result, 16'(ra * rb));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
